// File: rtl/bnn_seq_ctrl_if.sv
// Handshake bundle between the classifier controller and its sample source / result sink.
// Write-port signals exist only when BNN_WEIGHT_WR_EN is defined.
interface bnn_seq_ctrl_if #(
    parameter int IN_W = 7
);
    // Valid/ready: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds data stable while valid is high and ready is low.
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
`ifdef BNN_WEIGHT_WR_EN
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [IN_W-1:0] wr_data;
`endif

    modport slave (
`ifdef BNN_WEIGHT_WR_EN
        input  wr_en, wr_addr, wr_data,
`endif
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );

    modport master (
`ifdef BNN_WEIGHT_WR_EN
        output wr_en, wr_addr, wr_data,
`endif
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// Sequential BNN classifier: scans class weights one per clock, returns first zero-overlap class.
// Optional feature macro: BNN_WEIGHT_WR_EN (runtime-programmable weight registers).
module bnn_seq_ctrl #(
    parameter int         N_CLASS  = 10,
    parameter int         IN_W     = 7,
    parameter logic [3:0] NO_MATCH = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    bnn_seq_ctrl_if.slave      bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_CLASS - 1);

    function automatic logic [IN_W-1:0] weight_init(input int c);
        case (c)
            0:       return IN_W'(7'b1111011);
            1:       return IN_W'(7'b1101111);
            2:       return IN_W'(7'b1011101);
            3:       return IN_W'(7'b1101011);
            4:       return IN_W'(7'b1001111);
            5:       return IN_W'(7'b1011100);
            6:       return IN_W'(7'b1111010);
            7:       return IN_W'(7'b1011111);
            8:       return IN_W'(7'b1110111);
            9:       return IN_W'(7'b1101100);
            default: return '1;
        endcase
    endfunction

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_idx, w_idx_nxt;
    logic [3:0]      r_result, w_result_nxt;
    logic [IN_W-1:0] r_sample, w_sample_nxt;
    logic [IN_W-1:0] w_weight [16];
    logic            w_hit;

    // Full 16-entry table so the 4-bit index never falls outside the array.
`ifdef BNN_WEIGHT_WR_EN
    logic [IN_W-1:0] r_weight [16];
    logic            w_wr_ok;

    assign w_wr_ok = bus.wr_en && (r_state == S_IDLE) && ({1'b0, bus.wr_addr} < 5'(N_CLASS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 16; c++) r_weight[c] <= weight_init(c);
        end else if (w_wr_ok) begin
            r_weight[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        for (int c = 0; c < 16; c++) w_weight[c] = r_weight[c];
    end
`else
    always_comb begin
        for (int c = 0; c < 16; c++) w_weight[c] = weight_init(c);
    end
`endif

    assign w_hit = ((w_weight[r_idx] & r_sample) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_result <= '0;
            r_sample <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_result <= w_result_nxt;
            r_sample <= w_sample_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_result_nxt = r_result;
        w_sample_nxt = r_sample;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_sample_nxt = bus.in_data;
                    w_idx_nxt    = '0;
                    w_state_nxt  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    w_result_nxt = r_idx;
                    w_state_nxt  = S_DONE;
                end else if (r_idx == LAST_IDX) begin
                    w_result_nxt = NO_MATCH;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_data  = r_result;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl: randomized samples against a priority-scan reference model.
// Write-port scenarios are compiled in when BNN_WEIGHT_WR_EN is defined.
module tb_bnn_seq_ctrl;
  localparam int N_CLASS = 10;
  localparam int IN_W    = 7;
  localparam logic [IN_W-1:0] W_RST [10] = '{
    7'b1111011, 7'b1101111, 7'b1011101, 7'b1101011, 7'b1001111,
    7'b1011100, 7'b1111010, 7'b1011111, 7'b1110111, 7'b1101100};

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;
  logic [3:0] exp_q[$];
  logic [IN_W-1:0] model_w [N_CLASS];

  bnn_seq_ctrl_if #(.IN_W(IN_W)) bus_if ();

  bnn_seq_ctrl #(.N_CLASS(N_CLASS), .IN_W(IN_W), .NO_MATCH(4'hF)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: lowest class whose weight shares no set bit with the sample
  task automatic model_reset();
    for (int k = 0; k < N_CLASS; k++) model_w[k] = W_RST[k];
  endtask

  function automatic logic [3:0] model_class(input logic [IN_W-1:0] s);
    for (int k = 0; k < N_CLASS; k++)
      if ((model_w[k] & s) == 0) return 4'(k);
    return 4'hF;
  endfunction

  function automatic int model_latency(input logic [3:0] r);
    return (r == 4'hF) ? N_CLASS : int'(r) + 1;
  endfunction

  // driver: one full transaction, holding out_ready low for 'hold' cycles in DONE
  task automatic run_txn(input logic [IN_W-1:0] s, input int hold, input bit wr_in_scan);
    logic [3:0] exp_r;
    logic [3:0] got_r;
    int exp_lat;
    int lat;
    exp_r   = model_class(s);
    exp_lat = model_latency(exp_r);
    exp_q.push_back(exp_r);
    @(negedge clk);
    n_checks++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL idle_ready s=%b got=%b exp=1", s, bus_if.in_ready);
    else n_pass++;
    bus_if.in_data   = s;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = IN_W'($urandom);
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 40) begin
`ifdef BNN_WEIGHT_WR_EN
      if (wr_in_scan && lat == 1) begin
        bus_if.wr_en = 1'b1; bus_if.wr_addr = 4'd1; bus_if.wr_data = '0;
      end else begin
        bus_if.wr_en = 1'b0;
      end
`endif
      @(posedge clk);
      #1;
      lat++;
    end
`ifdef BNN_WEIGHT_WR_EN
    bus_if.wr_en = 1'b0;
`endif
    got_r = exp_q.pop_front();
    n_checks++;
    if (lat !== exp_lat) $display("FAIL latency s=%b got=%0d exp=%0d", s, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (bus_if.out_data !== got_r) $display("FAIL out_data s=%b got=%h exp=%h", s, bus_if.out_data, got_r);
    else n_pass++;
    n_checks++;
    if (bus_if.in_ready !== 1'b0 || bus_if.busy !== 1'b1)
      $display("FAIL done_flags s=%b in_ready=%b busy=%b exp 0/1", s, bus_if.in_ready, bus_if.busy);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== got_r || bus_if.in_ready !== 1'b0)
        $display("FAIL hold s=%b valid=%b data=%h ready=%b exp 1/%h/0", s, bus_if.out_valid,
                 bus_if.out_data, bus_if.in_ready, got_r);
      else n_pass++;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    n_checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.busy !== 1'b0)
      $display("FAIL release s=%b valid=%b ready=%b busy=%b exp 0/1/0", s, bus_if.out_valid,
               bus_if.in_ready, bus_if.busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.out_data !== 4'h0 || bus_if.busy !== 1'b0)
      $display("FAIL reset_state ready=%b valid=%b data=%h busy=%b exp 1/0/0/0", bus_if.in_ready,
               bus_if.out_valid, bus_if.out_data, bus_if.busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_txn(7'b0000100, 0, 1'b0);
    run_txn(7'b0100000, 0, 1'b0);
    run_txn(7'b1111111, 0, 1'b0);
    run_txn(7'b0000000, 0, 1'b0);
    run_txn(7'b0010000, 5, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_txn(IN_W'($urandom_range(0, 127)), $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) run_txn(IN_W'($urandom), 0, 1'b0);
  endtask

`ifdef BNN_WEIGHT_WR_EN
  task automatic do_write(input logic [3:0] a, input logic [IN_W-1:0] d);
    @(negedge clk);
    bus_if.wr_en = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0;
    if (a < N_CLASS) model_w[a] = d;
  endtask

  task automatic test_weight_write();
    do_write(4'd0, 7'b1111111);
    run_txn(7'b0000100, 0, 1'b0);
    run_txn(7'b1000000, 0, 1'b1);
    do_write(4'd12, 7'b0000000);
    run_txn(7'b1000000, 1, 1'b0);
    // write and accept on the same edge: scan must see the new c2
    @(negedge clk);
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 4'd2; bus_if.wr_data = '0;
    model_w[2] = '0;
    bus_if.in_data = 7'b1000000; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0; bus_if.in_valid = 1'b0;
    repeat (model_latency(model_class(7'b1000000))) @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== model_class(7'b1000000))
      $display("FAIL wr_with_accept valid=%b data=%h exp 1/%h", bus_if.out_valid, bus_if.out_data,
               model_class(7'b1000000));
    else n_pass++;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_scan();
    int seen;
    @(negedge clk);
    bus_if.in_data = 7'b1111111; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.out_data !== 4'h0 || bus_if.busy !== 1'b0)
      $display("FAIL async_reset ready=%b valid=%b data=%h busy=%b exp 1/0/0/0", bus_if.in_ready,
               bus_if.out_valid, bus_if.out_data, bus_if.busy);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL no_valid_after_reset got=%0d exp=0", seen);
    else n_pass++;
    bus_if.out_ready = 1'b0;
    run_txn(7'b0000100, 0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus_if.in_data   = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
`ifdef BNN_WEIGHT_WR_EN
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;
`endif
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
`ifdef BNN_WEIGHT_WR_EN
    test_weight_write();
`endif
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
